// File: rtl/tex_column_scheduler.sv
// Double-buffered texture column fetcher: fills a back bank from the
// texture ROM and hands it to the strip controller on frame boundaries.
module tex_column_scheduler #(
    parameter int LED_COUNT    = 52,
    parameter int TEX_WIDTH    = 128,
    parameter int NUM_TEXTURES = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  theta,
    input  logic [3:0]  texture_idx,
    input  logic        frame_done,
    output logic [14:0] rom_addr,
    input  logic [23:0] rom_data,
    input  logic [5:0]  rd_px,
    output logic [23:0] rd_pixel,
    output logic        col_valid,
    output logic        busy,
    output logic [7:0]  skip_cnt
);
    localparam int RW = $clog2(LED_COUNT + 1);
    localparam int AW = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
    localparam logic [14:0] STRIDE = 15'(TEX_WIDTH * NUM_TEXTURES);
    localparam logic [RW-1:0] LAST_ROW = RW'(LED_COUNT - 1);
    localparam logic [RW-1:0] END_ROW = RW'(LED_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        READY
    } state_t;

    state_t state_q, state_d;

    logic [3:0]    eff_tex;
    logic [9:0]    cur_pair;
    logic [14:0]   cur_base;
    int            col_w;
    int            off_w;

    logic          loaded_valid;
    logic [9:0]    loaded_pair;
    logic [9:0]    fetch_pair;
    logic [RW-1:0] row_q;
    logic          pend_valid;
    logic [RW-1:0] pend_row;
    logic          front_sel;

    logic          prev_valid;
    logic [9:0]    prev_pair;
    logic          seen_chg;
    logic          pair_chg;

    logic          start;
    logic          swap;
    logic          issue;

    logic [23:0]   bank0 [LED_COUNT];
    logic [23:0]   bank1 [LED_COUNT];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [23:0]   front_word;
    logic          rd_in_range;

    always_comb begin
        eff_tex = (int'(texture_idx) < NUM_TEXTURES) ? texture_idx : 4'd0;
        cur_pair = {theta, eff_tex};
        col_w = (int'(theta) * TEX_WIDTH) / 64;
        off_w = int'(eff_tex) * TEX_WIDTH;
        cur_base = 15'(col_w + off_w);
    end

    assign issue = (state_q == FETCH) && (row_q != END_ROW);
    assign busy = (state_q != IDLE);
    assign pair_chg = prev_valid && (cur_pair != prev_pair);

    always_comb begin
        state_d = state_q;
        start = 1'b0;
        swap = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!loaded_valid || cur_pair != loaded_pair) begin
                    start = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // rom_data lags rom_addr by one cycle, so wait for the last write
                if (pend_valid && pend_row == LAST_ROW) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (frame_done) begin
                    swap = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rom_addr <= '0;
            row_q <= '0;
            pend_valid <= 1'b0;
            pend_row <= '0;
            fetch_pair <= '0;
            loaded_valid <= 1'b0;
            loaded_pair <= '0;
            front_sel <= 1'b0;
            col_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_valid <= issue;
            pend_row <= row_q;
            if (start) begin
                rom_addr <= cur_base;
                row_q <= '0;
                fetch_pair <= cur_pair;
            end else if (issue) begin
                row_q <= row_q + 1'b1;
                if (row_q != LAST_ROW) begin
                    rom_addr <= rom_addr + STRIDE;
                end
            end
            if (swap) begin
                front_sel <= ~front_sel;
                col_valid <= 1'b1;
                loaded_valid <= 1'b1;
                loaded_pair <= fetch_pair;
            end
        end
    end

    // Every pair change after the first one in a swap window loses a column
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_valid <= 1'b0;
            prev_pair <= '0;
            seen_chg <= 1'b0;
            skip_cnt <= '0;
        end else begin
            prev_valid <= 1'b1;
            prev_pair <= cur_pair;
            if (swap) begin
                seen_chg <= pair_chg;
            end else if (pair_chg) begin
                seen_chg <= 1'b1;
            end
            if (pair_chg && seen_chg && !swap && skip_cnt != 8'hFF) begin
                skip_cnt <= skip_cnt + 8'd1;
            end
        end
    end

    assign wr_idx = AW'(pend_row);
    assign rd_idx = AW'(rd_px);

    always_ff @(posedge clk) begin
        if (reset_n && pend_valid && state_q == FETCH) begin
            if (front_sel) begin
                bank0[wr_idx] <= rom_data;
            end else begin
                bank1[wr_idx] <= rom_data;
            end
        end
    end

    assign rd_in_range = (32'(rd_px) < 32'(LED_COUNT));
    assign front_word = front_sel ? bank1[rd_idx] : bank0[rd_idx];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_pixel <= '0;
        end else if (col_valid && rd_in_range) begin
            rd_pixel <= front_word;
        end else begin
            rd_pixel <= '0;
        end
    end

endmodule

// File: doc/tex_column_scheduler.md
TEX_COLUMN_SCHEDULER -- requirements
Module: tex_column_scheduler

Interface
REQ-001 SHALL have parameter LED_COUNT, default 52, strip length in pixels.
REQ-002 SHALL have parameter TEX_WIDTH, default 128, columns per texture.
REQ-003 SHALL have parameter NUM_TEXTURES, default 3, textures in ROM.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port theta  input  6  angle index from beam tracker.
REQ-007 SHALL have port texture_idx  input  4  texture select from MMIO.
REQ-008 SHALL have port frame_done  input  1  one-cycle pulse: strip finished a frame/latch.
REQ-009 SHALL have port rom_addr  output  15  texture ROM address.
REQ-010 SHALL have port rom_data  input  24  ROM data, valid one cycle after rom_addr.
REQ-011 SHALL have port rd_px  input  6  pixel index requested by strip controller.
REQ-012 SHALL have port rd_pixel  output  24  GRB pixel for rd_px, registered.
REQ-013 SHALL have port col_valid  output  1  front bank holds a complete column.
REQ-014 SHALL have port busy  output  1  FSM not in IDLE.
REQ-015 SHALL have port skip_cnt  output  8  saturating count of dropped columns.

Function
REQ-016 SHALL hold two LED_COUNT x 24 column banks, front (read by strip) and back (filled from ROM).
REQ-017 SHALL implement FSM states IDLE, FETCH, READY.
REQ-018 IDLE: when {theta, effective texture} differs from last-loaded pair, SHALL latch col = theta*TEX_WIDTH/64 (theta<<1 at defaults) and offset = effective texture*TEX_WIDTH, go to FETCH next cycle.
REQ-019 Effective texture SHALL equal texture_idx when < NUM_TEXTURES, else 0.
REQ-020 FETCH: SHALL issue rom_addr = row*(TEX_WIDTH*NUM_TEXTURES) + col + offset for row 0..LED_COUNT-1, one row per cycle, no gaps.
REQ-021 SHALL write rom_data into back bank at row issued the previous cycle; after last write go to READY.
REQ-022 Change detected at cycle T SHALL give FETCH rows at T+1..T+52 and READY at T+54 (defaults).
REQ-023 READY: on frame_done SHALL swap banks, set col_valid=1, record loaded pair, return to IDLE next cycle.
REQ-024 frame_done in IDLE or FETCH SHALL not swap; front bank and col_valid unchanged.
REQ-025 Pair change during FETCH or READY SHALL not abort; it is re-evaluated in IDLE after the swap.
REQ-026 Pair changing more than once between two swaps SHALL increment skip_cnt once per extra change, saturating at 255.
REQ-027 rd_pixel SHALL equal front[rd_px] one cycle after rd_px; 0 when rd_px >= LED_COUNT or col_valid=0.
REQ-028 rom_addr SHALL hold its last value outside FETCH; busy=1 in FETCH and READY.
REQ-029 frame_done coincident with READY entry SHALL be ignored; swap needs frame_done while in READY.

Reset
REQ-030 reset_n=0 at a clock edge SHALL force IDLE, col_valid=0, busy=0, skip_cnt=0, rom_addr=0, rd_pixel=0, loaded pair invalid.
REQ-031 Reset mid-FETCH SHALL abandon the fill; first post-reset IDLE cycle SHALL start a new fetch for current inputs.
REQ-032 Bank contents need not be cleared; col_valid=0 masks them.

Verification
REQ-033 Reset release, theta=5, texture_idx=1 -> rom_addr 138, 522, 906 ... (row*384+10+128) on consecutive cycles; READY at T+54.
REQ-034 READY then frame_done, rd_px=3 -> col_valid=1; rd_pixel equals ROM word 3*384+138 one cycle later.
REQ-035 texture_idx=7, theta=0 -> first rom_addr 0 (texture clamped to 0).
REQ-036 theta stepped 5->6->7->8 during one FETCH, no frame_done -> skip_cnt=2; after swap, fetch starts for theta=8 (col 16).
REQ-037 reset_n=0 at row 20 of FETCH -> next cycle busy=0, col_valid=0, skip_cnt=0; refetch begins from row 0.
REQ-038 rd_px=52 or 63 with col_valid=1 -> rd_pixel=0.
